// File: rtl/grid_serial_tx.sv
// rtl/grid_serial_tx.sv - grid word serializer, MSB first, programmable bit period
// Captures DATA_IN on START and shifts it out with per-bit strobes and a DONE pulse.
module grid_serial_tx #(
  parameter int DATA_SIZE    = 64,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  input  logic                 START,
  input  logic                 ABORT,
  output logic                 SERIAL_OUT,
  output logic                 SERIAL_VALID,
  output logic                 BIT_STROBE,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int BW = $clog2(DATA_SIZE);
  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_SIZE - 1);
  localparam logic [PW-1:0] PER_LAST = PW'(CLKS_PER_BIT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [DATA_SIZE-1:0] shift_reg, shift_nxt;
  logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
  logic [PW-1:0]        per_cnt, per_cnt_nxt;
  logic                 done_nxt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      per_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      bit_cnt   <= bit_cnt_nxt;
      per_cnt   <= per_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg;
    bit_cnt_nxt = bit_cnt;
    per_cnt_nxt = per_cnt;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (START && !ABORT) begin
          state_nxt   = SHIFT;
          shift_nxt   = DATA_IN;
          bit_cnt_nxt = BIT_LAST;
          per_cnt_nxt = '0;
        end
      end
      SHIFT: begin
        // ABORT outranks the final-bit transition, so it also suppresses DONE
        if (ABORT) begin
          state_nxt   = IDLE;
          shift_nxt   = '0;
          bit_cnt_nxt = '0;
          per_cnt_nxt = '0;
        end else if (per_cnt == PER_LAST) begin
          per_cnt_nxt = '0;
          if (bit_cnt == '0) begin
            state_nxt = IDLE;
            shift_nxt = '0;
            done_nxt  = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt - 1'b1;
            shift_nxt   = {shift_reg[DATA_SIZE-2:0], 1'b0};
          end
        end else begin
          per_cnt_nxt = per_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state they describe
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      SERIAL_OUT   <= 1'b0;
      SERIAL_VALID <= 1'b0;
      BIT_STROBE   <= 1'b0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
    end else begin
      SERIAL_OUT   <= (state_nxt == SHIFT) && shift_nxt[DATA_SIZE-1];
      SERIAL_VALID <= (state_nxt == SHIFT);
      BIT_STROBE   <= (state_nxt == SHIFT) && (per_cnt_nxt == PER_LAST);
      BUSY         <= (state_nxt == SHIFT);
      DONE         <= done_nxt;
    end
  end

endmodule

// File: tb/tb_grid_serial_tx.sv
// tb/tb_grid_serial_tx.sv - self-checking bench for grid_serial_tx
// Three 8-bit instances with bit periods of 1, 2 and 3 clocks share one clock and reset.
module tb_grid_serial_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din   [3];
  logic       start [3];
  logic       abort [3];
  logic       so    [3];
  logic       sv    [3];
  logic       bs    [3];
  logic       by    [3];
  logic       dn    [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  grid_serial_tx #(.DATA_SIZE(8), .CLKS_PER_BIT(1)) u_cpb1 (
    .CLK(clk), .RESET(rst), .DATA_IN(din[0]), .START(start[0]), .ABORT(abort[0]),
    .SERIAL_OUT(so[0]), .SERIAL_VALID(sv[0]), .BIT_STROBE(bs[0]), .BUSY(by[0]), .DONE(dn[0]));

  grid_serial_tx #(.DATA_SIZE(8), .CLKS_PER_BIT(2)) u_cpb2 (
    .CLK(clk), .RESET(rst), .DATA_IN(din[1]), .START(start[1]), .ABORT(abort[1]),
    .SERIAL_OUT(so[1]), .SERIAL_VALID(sv[1]), .BIT_STROBE(bs[1]), .BUSY(by[1]), .DONE(dn[1]));

  grid_serial_tx #(.DATA_SIZE(8), .CLKS_PER_BIT(3)) u_cpb3 (
    .CLK(clk), .RESET(rst), .DATA_IN(din[2]), .START(start[2]), .ABORT(abort[2]),
    .SERIAL_OUT(so[2]), .SERIAL_VALID(sv[2]), .BIT_STROBE(bs[2]), .BUSY(by[2]), .DONE(dn[2]));

  task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    n_cmp++;
    if (obs_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs_v, exp_v, $time);
    end
  endtask

  // {SERIAL_VALID, BUSY, SERIAL_OUT, BIT_STROBE, DONE}
  function automatic logic [4:0] obs(input int i);
    return {sv[i], by[i], so[i], bs[i], dn[i]};
  endfunction

  task automatic start_frame(input int i, input logic [7:0] w);
    @(posedge clk); #1;
    din[i]   = w;
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
    din[i]   = 8'($urandom);
  endtask

  // Reference: cycle k of a frame carries bit 7-k/cpb and strobes on the last cycle of each period.
  task automatic expect_frame(input int i, input logic [7:0] w, input int abort_k);
    int         cpb = i + 1;
    int         ns  = 0;
    logic [7:0] rx  = 8'h00;
    logic [4:0] e;
    for (int k = 0; k < 8 * cpb; k++) begin
      @(negedge clk);
      e = {1'b1, 1'b1, w[7 - k / cpb], (k % cpb) == (cpb - 1), 1'b0};
      chk($sformatf("frame%0d_k%0d", i, k), obs(i), e);
      if (bs[i]) begin
        rx = {rx[6:0], so[i]};
        ns++;
      end
      if (k == abort_k) begin
        abort[i] = 1'b1;
        @(negedge clk);
        chk("abort_idle", obs(i), 5'b00000);
        abort[i] = 1'b0;
        @(negedge clk);
        chk("abort_nodone", obs(i), 5'b00000);
        return;
      end
    end
    @(negedge clk);
    chk("done", obs(i), 5'b00001);
    chk("loopback", rx, w);
    chk("strobes", ns, 8);
  endtask

  initial begin
    logic [7:0] w;
    int         i;
    int         ab;
    for (int j = 0; j < 3; j++) begin
      din[j]   = 8'h00;
      start[j] = 1'b0;
      abort[j] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int j = 0; j < 3; j++) chk($sformatf("reset%0d", j), obs(j), 5'b00000);
    rst = 1'b0;

    start_frame(0, 8'hA5);
    expect_frame(0, 8'hA5, -1);
    start_frame(2, 8'h81);
    expect_frame(2, 8'h81, -1);
    start_frame(1, 8'h3C);
    expect_frame(1, 8'h3C, -1);
    start_frame(1, 8'h00);
    expect_frame(1, 8'h00, -1);
    start_frame(1, 8'hFF);
    expect_frame(1, 8'hFF, -1);

    // START held high: second frame is captured in the DONE cycle
    @(posedge clk); #1;
    din[0]   = 8'hF0;
    start[0] = 1'b1;
    @(posedge clk); #1;
    din[0] = 8'h0F;
    expect_frame(0, 8'hF0, -1);
    @(posedge clk); #1;
    start[0] = 1'b0;
    expect_frame(0, 8'h0F, -1);

    start_frame(0, 8'hFF);
    expect_frame(0, 8'hFF, 4);
    start_frame(0, 8'h5A);
    expect_frame(0, 8'h5A, -1);

    // asynchronous reset between clock edges mid-frame
    start_frame(2, 8'hC3);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int j = 0; j < 3; j++) chk($sformatf("async_reset%0d", j), obs(j), 5'b00000);
    @(negedge clk);
    chk("reset_held", obs(2), 5'b00000);
    rst = 1'b0;
    start_frame(2, 8'h96);
    expect_frame(2, 8'h96, -1);

    for (int n = 0; n < 12; n++) begin
      i  = int'($urandom_range(0, 2));
      w  = 8'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8 * (i + 1) - 1)) : -1;
      start_frame(i, w);
      expect_frame(i, w, ab);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
